ekf_step_sequencer: RTL
=======================

// Module: ekf_step_sequencer
// PURPOSE
//  Sequences one EKF iteration per current-sample strobe around the combinational state-prediction datapath.
//  Order: latch sample -> sin/cos of theta -> predict + covariance -> correction -> theta wrap -> commit.
//  Holds the estimated state registers (ialpha, ibeta, omega, theta) that feed the prediction datapath.
//  Flags sample overruns and stalled stages.
// PARAMETERS
//  N        32       word width, signed fixed point
//  Q        18       fractional bits
//  TIMEOUT  1023     max cycles waiting on any *_done before abort (>=1)
//  PI_Q     823550   round(pi*2^Q)
//  TWOPI_Q  1647099  round(2*pi*2^Q)
// PORTS
//  clk           in   1     clock, rising edge
//  reset         in   1     synchronous, active-high
//  sample_valid  in   1     1-cycle strobe: new ialpha_m/ibeta_m/valpha_m/vbeta_m
//  ialpha_m,ibeta_m,valpha_m,vbeta_m  in  N each  measured currents/voltages
//  trig_start    out  1     1-cycle pulse: start sin/cos of trig_angle
//  trig_angle    out  N     angle to trig unit (= theta register)
//  trig_done     in   1     1-cycle strobe: sin_in/cos_in valid
//  sin_in,cos_in in   N     trig results
//  ialpha,ibeta,omega,theta  out  N each  state registers to prediction datapath
//  valpha,vbeta,stheta,ctheta  out  N each  latched inputs to prediction datapath
//  ialphae,ibetae,omegae,thetae  in  N each  predicted state (combinational)
//  cov_start     out  1     1-cycle pulse: run covariance predict/gain
//  cov_done      in   1     1-cycle strobe
//  corr_start    out  1     1-cycle pulse: run state correction
//  xp_ialpha,xp_ibeta,xp_omega,xp_theta  out  N each  latched prediction
//  zm_ialpha,zm_ibeta  out  N each  latched measurement for correction
//  corr_done     in   1     1-cycle strobe: xc_* valid
//  xc_ialpha,xc_ibeta,xc_omega,xc_theta  in  N each  corrected state
//  busy          out  1     high in every state except IDLE
//  est_valid     out  1     1-cycle pulse: state registers committed
//  overrun_cnt   out  16    saturating count of dropped samples
//  fault         out  1     sticky stage-timeout flag
// BEHAVIOUR
//  Reset: all outputs and registers 0, FSM=IDLE. Takes priority over everything, including mid-iteration.
//  States: IDLE, TRIG, PRED, COV, CORR, WRAP.
//  IDLE: sample_valid -> latch *_m and v*, trig_start=1 next cycle, go TRIG.
//   Sample at edge k gives trig_start high in cycle k+1.
//  TRIG: on trig_done, latch stheta/ctheta, go PRED.
//  PRED: one cycle; prediction inputs are stable.
//   Latch xp_* <= {ialphae,ibetae,omegae,thetae}.
//   Pulse cov_start next cycle; go COV.
//  COV: on cov_done, pulse corr_start next cycle; go CORR.
//  CORR: on corr_done, capture xc_*; go WRAP.
//  WRAP: single-step theta wrap into [-PI_Q, PI_Q):
//   - xc_theta >= PI_Q: theta <= xc_theta - TWOPI_Q
//   - xc_theta < -PI_Q: theta <= xc_theta + TWOPI_Q
//   - otherwise: theta <= xc_theta
//   Also load ialpha/ibeta/omega <= xc_*, pulse est_valid, go IDLE.
//   Latency from trig_done/cov_done/corr_done to the next action is exactly 1 cycle.
//  Done strobes: a *_done seen outside its wait state is ignored.
//  Overrun: sample_valid while busy (including the WRAP cycle) is dropped.
//   overrun_cnt += 1, saturating at 16'hFFFF; in-flight iteration is unaffected.
//  Timeout: wait counter clears on entering TRIG/COV/CORR.
//   Counter reaching TIMEOUT without the done strobe -> fault=1, FSM=IDLE.
//   State registers and overrun_cnt are kept; no est_valid.
//   Done strobe on the same cycle as timeout: the done wins.
//  fault clears only on reset; the FSM still accepts new samples while fault=1.
//  Arithmetic: wrap add/sub are N-bit signed; no saturation needed since |theta| < 2*PI_Q.
// TESTING
//  T1 reset, sample_valid, done strobes 2 cycles after each start
//     -> trig_start @k+1; est_valid once; busy low after.
//  T2 xc_theta=823550 -> theta=-823549; xc_theta=-823551 -> theta=823548; xc_theta=0 -> 0.
//  T3 three sample_valid during busy -> overrun_cnt=3; preload 16'hFFFE plus 3 drops -> 16'hFFFF.
//  T4 withhold cov_done -> fault=1 and IDLE after TIMEOUT cycles; next sample completes normally.
//  T5 reset asserted during CORR -> next cycle all outputs 0, IDLE; a stale corr_done is ignored.
//  T6 spurious trig_done/corr_done while IDLE -> no state change, no pulses.

Source files
------------

// File: rtl/ekf_step_sequencer.sv
// ekf_step_sequencer
// Runs one EKF iteration per current-sample strobe around an external
// combinational prediction datapath and the trig / covariance / correction
// units. Owns the estimated state registers and wraps theta on commit.
//
// Start/done protocol: each *_start output is a one-cycle pulse issued on the
// cycle the FSM enters the matching wait state; the unit answers with a
// one-cycle *_done strobe on any later cycle (or the same cycle as the start).
// A done strobe is acted on only while the FSM waits for it, and the next
// action follows exactly one cycle after the strobe. A wait that lasts
// TIMEOUT cycles without its strobe aborts the iteration and sets the sticky
// fault flag.

module ekf_step_sequencer #(
    parameter int N       = 32,
    parameter int Q       = 18,
    parameter int TIMEOUT = 1023,
    parameter int PI_Q    = 823550,
    parameter int TWOPI_Q = 1647099
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         sample_valid,
    input  logic [N-1:0] ialpha_m,
    input  logic [N-1:0] ibeta_m,
    input  logic [N-1:0] valpha_m,
    input  logic [N-1:0] vbeta_m,

    output logic         trig_start,
    output logic [N-1:0] trig_angle,
    input  logic         trig_done,
    input  logic [N-1:0] sin_in,
    input  logic [N-1:0] cos_in,

    output logic [N-1:0] ialpha,
    output logic [N-1:0] ibeta,
    output logic [N-1:0] omega,
    output logic [N-1:0] theta,
    output logic [N-1:0] valpha,
    output logic [N-1:0] vbeta,
    output logic [N-1:0] stheta,
    output logic [N-1:0] ctheta,
    input  logic [N-1:0] ialphae,
    input  logic [N-1:0] ibetae,
    input  logic [N-1:0] omegae,
    input  logic [N-1:0] thetae,

    output logic         cov_start,
    input  logic         cov_done,

    output logic         corr_start,
    output logic [N-1:0] xp_ialpha,
    output logic [N-1:0] xp_ibeta,
    output logic [N-1:0] xp_omega,
    output logic [N-1:0] xp_theta,
    output logic [N-1:0] zm_ialpha,
    output logic [N-1:0] zm_ibeta,
    input  logic         corr_done,
    input  logic [N-1:0] xc_ialpha,
    input  logic [N-1:0] xc_ibeta,
    input  logic [N-1:0] xc_omega,
    input  logic [N-1:0] xc_theta,

    output logic         busy,
    output logic         est_valid,
    output logic [15:0]  overrun_cnt,
    output logic         fault,
    output logic [2:0]   state_dbg
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic signed [N-1:0] PI_W    = N'(PI_Q);
    localparam logic signed [N-1:0] TWOPI_W = N'(TWOPI_Q);

    if (TIMEOUT < 1 || Q < 0 || Q >= N) begin : g_bad_params
        $error("ekf_step_sequencer: TIMEOUT must be >= 1 and 0 <= Q < N");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_PRED = 3'd2,
        S_COV  = 3'd3,
        S_CORR = 3'd4,
        S_WRAP = 3'd5
    } state_t;

    state_t                 state;
    logic [CW-1:0]          wait_cnt;
    logic                   wait_expired;
    logic [N-1:0]           xc_ialpha_q;
    logic [N-1:0]           xc_ibeta_q;
    logic [N-1:0]           xc_omega_q;
    logic signed [N-1:0]    xc_theta_q;
    logic signed [N-1:0]    theta_wrapped;

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
    assign trig_angle   = theta;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    // Single-step wrap of the corrected angle into [-pi, pi).
    always_comb begin
        theta_wrapped = xc_theta_q;
        if (xc_theta_q >= PI_W) begin
            theta_wrapped = xc_theta_q - TWOPI_W;
        end else if (xc_theta_q < -PI_W) begin
            theta_wrapped = xc_theta_q + TWOPI_W;
        end
    end

    // Iteration FSM with all latched operands, pulses, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            trig_start  <= 1'b0;
            cov_start   <= 1'b0;
            corr_start  <= 1'b0;
            est_valid   <= 1'b0;
            fault       <= 1'b0;
            overrun_cnt <= '0;
            ialpha      <= '0;
            ibeta       <= '0;
            omega       <= '0;
            theta       <= '0;
            valpha      <= '0;
            vbeta       <= '0;
            stheta      <= '0;
            ctheta      <= '0;
            xp_ialpha   <= '0;
            xp_ibeta    <= '0;
            xp_omega    <= '0;
            xp_theta    <= '0;
            zm_ialpha   <= '0;
            zm_ibeta    <= '0;
            xc_ialpha_q <= '0;
            xc_ibeta_q  <= '0;
            xc_omega_q  <= '0;
            xc_theta_q  <= '0;
        end else begin
            trig_start <= 1'b0;
            cov_start  <= 1'b0;
            corr_start <= 1'b0;
            est_valid  <= 1'b0;

            // A sample arriving mid-iteration is dropped and counted.
            if (sample_valid && state != S_IDLE && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        zm_ialpha  <= ialpha_m;
                        zm_ibeta   <= ibeta_m;
                        valpha     <= valpha_m;
                        vbeta      <= vbeta_m;
                        trig_start <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (trig_done) begin
                        stheta <= sin_in;
                        ctheta <= cos_in;
                        state  <= S_PRED;
                    end else if (wait_expired) begin
                        fault <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_PRED: begin
                    xp_ialpha <= ialphae;
                    xp_ibeta  <= ibetae;
                    xp_omega  <= omegae;
                    xp_theta  <= thetae;
                    cov_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= S_COV;
                end
                S_COV: begin
                    if (cov_done) begin
                        corr_start <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_CORR;
                    end else if (wait_expired) begin
                        fault <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_CORR: begin
                    if (corr_done) begin
                        xc_ialpha_q <= xc_ialpha;
                        xc_ibeta_q  <= xc_ibeta;
                        xc_omega_q  <= xc_omega;
                        xc_theta_q  <= xc_theta;
                        state       <= S_WRAP;
                    end else if (wait_expired) begin
                        fault <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WRAP: begin
                    ialpha    <= xc_ialpha_q;
                    ibeta     <= xc_ibeta_q;
                    omega     <= xc_omega_q;
                    theta     <= theta_wrapped;
                    est_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
